// File: rtl/memoria_dados_if.sv
// rtl/memoria_dados_if.sv - request/response bundle between the load/store stage and memoria_dados
interface memoria_dados_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [31:0]       endereco;
    logic [DATA_W-1:0] entrada;
    logic [1:0]        tamanho;
    logic              sinal;
    logic              pronto;
    logic [DATA_W-1:0] saida;
    logic              valido;
    logic              erro;

    modport master (
        output req, we, endereco, entrada, tamanho, sinal,
        input  pronto, saida, valido, erro
    );

    modport slave (
        input  req, we, endereco, entrada, tamanho, sinal,
        output pronto, saida, valido, erro
    );
endinterface

// File: rtl/memoria_dados.sv
// rtl/memoria_dados.sv - byte-addressed data memory with sub-word access and checks
// Optional reset-time zero sweep of the array is built when MEM_CLEAR_EN is defined.
module memoria_dados #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    memoria_dados_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [BYTES-1:0] BE_BYTE = BYTES'(1);
    localparam logic [BYTES-1:0] BE_HALF = BYTES'(3);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              pronto_q, pronto_d;
    logic              valido_q, valido_d;
    logic              erro_q, erro_d;
    logic [DATA_W-1:0] saida_q, saida_d;
    logic              pend_ld_q, pend_ld_d;
    logic              pend_err_q, pend_err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [LB-1:0]     lane_q, lane_d;
    logic [1:0]        tam_q, tam_d;
    logic              sinal_q, sinal_d;

    logic              aceita, erro_acc;
    logic [LB-1:0]     lane;
    logic [ADDR_W-1:0] idx;
    logic [BYTES-1:0]  be;
    logic [DATA_W-1:0] wdata, rshift, rext;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [BYTES-1:0]  wr_be;
    logic [DATA_W-1:0] wr_data;

    always_comb begin
        lane     = bus.endereco[LB-1:0];
        idx      = bus.endereco[LB+ADDR_W-1:LB];
        erro_acc = (bus.endereco >> (LB + ADDR_W)) != 32'd0;
        be       = '0;
        case (bus.tamanho)
            2'b00: be = BE_BYTE << lane;
            2'b01: begin
                be = BE_HALF << lane;
                if (lane[0]) erro_acc = 1'b1;
            end
            2'b10: begin
                be = '1;
                if (lane != '0) erro_acc = 1'b1;
            end
            default: erro_acc = 1'b1;
        endcase
        wdata  = bus.entrada << {lane, 3'b000};
        aceita = bus.req && pronto_q;
    end

`ifdef MEM_CLEAR_EN
    typedef enum logic {LIMPA, PRONTO} estado_t;
    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        pronto_d = (estado_q == PRONTO);
        if (estado_q == LIMPA) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {ADDR_W{1'b1}}) estado_d = PRONTO;
        end
    end

    // The sweep owns the write port until the last word is zeroed.
    always_comb begin
        if (estado_q == LIMPA) begin
            wr_en   = 1'b1;
            wr_idx  = cnt_q;
            wr_be   = '1;
            wr_data = '0;
        end else begin
            wr_en   = rst_n && aceita && bus.we && !erro_acc;
            wr_idx  = idx;
            wr_be   = be;
            wr_data = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q <= LIMPA;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    always_comb begin
        pronto_d = 1'b1;
        wr_en    = rst_n && aceita && bus.we && !erro_acc;
        wr_idx   = idx;
        wr_be    = be;
        wr_data  = wdata;
    end
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wr_be[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Stage 1 captures the raw word; stage 2 aligns, extends and presents it.
    always_comb begin
        pend_ld_d  = aceita && !bus.we && !erro_acc;
        pend_err_d = aceita && erro_acc;
        rdata_d    = mem_q[idx];
        lane_d     = lane;
        tam_d      = bus.tamanho;
        sinal_d    = bus.sinal;

        rshift = rdata_q >> {lane_q, 3'b000};
        case (tam_q)
            2'b00:   rext = sinal_q ? {{(DATA_W-8){rshift[7]}}, rshift[7:0]}
                                    : {{(DATA_W-8){1'b0}}, rshift[7:0]};
            2'b01:   rext = sinal_q ? {{(DATA_W-16){rshift[15]}}, rshift[15:0]}
                                    : {{(DATA_W-16){1'b0}}, rshift[15:0]};
            default: rext = rshift;
        endcase

        valido_d = pend_ld_q;
        erro_d   = pend_err_q;
        saida_d  = saida_q;
        if (pend_err_q)     saida_d = '0;
        else if (pend_ld_q) saida_d = rext;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pronto_q   <= 1'b0;
            valido_q   <= 1'b0;
            erro_q     <= 1'b0;
            saida_q    <= '0;
            pend_ld_q  <= 1'b0;
            pend_err_q <= 1'b0;
            rdata_q    <= '0;
            lane_q     <= '0;
            tam_q      <= '0;
            sinal_q    <= 1'b0;
        end else begin
            pronto_q   <= pronto_d;
            valido_q   <= valido_d;
            erro_q     <= erro_d;
            saida_q    <= saida_d;
            pend_ld_q  <= pend_ld_d;
            pend_err_q <= pend_err_d;
            rdata_q    <= rdata_d;
            lane_q     <= lane_d;
            tam_q      <= tam_d;
            sinal_q    <= sinal_d;
        end
    end

    assign bus.pronto = pronto_q;
    assign bus.saida  = saida_q;
    assign bus.valido = valido_q;
    assign bus.erro   = erro_q;
endmodule
